// File: rtl/mor1kx_cfgrs_spr_slave.sv
// SPR-bus responder for the read-only group-0 configuration registers.
// Fixed-latency single-pulse ack; writes are acked and optionally logged as errors.
module mor1kx_cfgrs_spr_slave #(
  parameter int    OPTION_READ_LATENCY = 1,
  parameter string FEATURE_WRITE_ERROR = "ENABLED"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] spr_bus_addr_i,
  input  logic        spr_bus_we_i,
  input  logic        spr_bus_stb_i,
  input  logic [31:0] spr_bus_dat_i,
  input  logic [31:0] spr_vr,
  input  logic [31:0] spr_vr2,
  input  logic [31:0] spr_upr,
  input  logic [31:0] spr_cpucfgr,
  input  logic [31:0] spr_dmmucfgr,
  input  logic [31:0] spr_immucfgr,
  input  logic [31:0] spr_dccfgr,
  input  logic [31:0] spr_iccfgr,
  input  logic [31:0] spr_dcfgr,
  input  logic [31:0] spr_pccfgr,
  input  logic [31:0] spr_avr,
  input  logic        err_clear_i,
  output logic [31:0] spr_bus_dat_o,
  output logic        spr_bus_ack_o,
  output logic        spr_access_err_o,
  output logic [7:0]  spr_err_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  localparam bit         WRITE_ERR = (FEATURE_WRITE_ERROR != "NONE");
  localparam logic [1:0] CNT_INIT  = 2'(OPTION_READ_LATENCY - 1);

  if (OPTION_READ_LATENCY < 1 || OPTION_READ_LATENCY > 4) begin : g_bad_latency
    $error("OPTION_READ_LATENCY must be within 1..4");
  end

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] snap;
  logic        we_q;
  logic        hit;
  logic [31:0] sel;

  // Write data is never stored; these registers are read-only.
  logic unused_dat;
  assign unused_dat = ^spr_bus_dat_i;

  always_comb begin
    hit = (spr_bus_addr_i[15:11] == 5'd0) && (spr_bus_addr_i[10:0] <= 11'h00A);
    sel = '0;
    case (spr_bus_addr_i[3:0])
      4'h0:    sel = spr_vr;
      4'h1:    sel = spr_upr;
      4'h2:    sel = spr_cpucfgr;
      4'h3:    sel = spr_dmmucfgr;
      4'h4:    sel = spr_immucfgr;
      4'h5:    sel = spr_dccfgr;
      4'h6:    sel = spr_iccfgr;
      4'h7:    sel = spr_dcfgr;
      4'h8:    sel = spr_pccfgr;
      4'h9:    sel = spr_vr2;
      4'hA:    sel = spr_avr;
      default: sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      snap             <= '0;
      we_q             <= 1'b0;
      spr_bus_ack_o    <= 1'b0;
      spr_bus_dat_o    <= '0;
      spr_access_err_o <= 1'b0;
      spr_err_count_o  <= '0;
    end else begin
      spr_bus_ack_o <= 1'b0;
      spr_bus_dat_o <= '0;
      case (state)
        S_IDLE: begin
          if (spr_bus_stb_i && hit) begin
            we_q <= spr_bus_we_i;
            snap <= sel;
            // Latency 1 loads the ack/data registers straight from the mux.
            if (OPTION_READ_LATENCY == 1) begin
              state         <= S_ACK;
              spr_bus_ack_o <= 1'b1;
              spr_bus_dat_o <= spr_bus_we_i ? '0 : sel;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!spr_bus_stb_i) begin
            state <= S_IDLE;
          end else if (cnt == 2'd1) begin
            state         <= S_ACK;
            spr_bus_ack_o <= 1'b1;
            spr_bus_dat_o <= we_q ? '0 : snap;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_ACK:   state <= S_HOLD;
        S_HOLD:  if (!spr_bus_stb_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // A clear coinciding with an erroring write leaves exactly one logged error.
      if (state == S_ACK && we_q && WRITE_ERR) begin
        spr_access_err_o <= 1'b1;
        if (err_clear_i)
          spr_err_count_o <= 8'd1;
        else if (spr_err_count_o != 8'hFF)
          spr_err_count_o <= spr_err_count_o + 8'd1;
      end else if (err_clear_i) begin
        spr_access_err_o <= 1'b0;
        spr_err_count_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_slave.sv
// Bench for mor1kx_cfgrs_spr_slave: four configurations share one stimulus stream
// and are checked each cycle against a transaction-timing model plus literal checks.
module tb_mor1kx_cfgrs_spr_slave;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] dat_i = '0;
  logic        clr = 1'b0;
  logic [31:0] regs [0:10];

  logic        ack [0:3];
  logic [31:0] dat [0:3];
  logic        err [0:3];
  logic [7:0]  cnt [0:3];

  // Instance i: latency lat[i], write-error logging feat[i].
  int unsigned lat  [0:3] = '{1, 3, 4, 2};
  bit          feat [0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};

  mor1kx_cfgrs_spr_slave #(.OPTION_READ_LATENCY(1), .FEATURE_WRITE_ERROR("ENABLED")) u_l1 (
    .clk(clk), .rst(rst), .spr_bus_addr_i(addr), .spr_bus_we_i(we), .spr_bus_stb_i(stb),
    .spr_bus_dat_i(dat_i), .spr_vr(regs[0]), .spr_vr2(regs[9]), .spr_upr(regs[1]),
    .spr_cpucfgr(regs[2]), .spr_dmmucfgr(regs[3]), .spr_immucfgr(regs[4]), .spr_dccfgr(regs[5]),
    .spr_iccfgr(regs[6]), .spr_dcfgr(regs[7]), .spr_pccfgr(regs[8]), .spr_avr(regs[10]),
    .err_clear_i(clr), .spr_bus_dat_o(dat[0]), .spr_bus_ack_o(ack[0]),
    .spr_access_err_o(err[0]), .spr_err_count_o(cnt[0]));

  mor1kx_cfgrs_spr_slave #(.OPTION_READ_LATENCY(3), .FEATURE_WRITE_ERROR("ENABLED")) u_l3 (
    .clk(clk), .rst(rst), .spr_bus_addr_i(addr), .spr_bus_we_i(we), .spr_bus_stb_i(stb),
    .spr_bus_dat_i(dat_i), .spr_vr(regs[0]), .spr_vr2(regs[9]), .spr_upr(regs[1]),
    .spr_cpucfgr(regs[2]), .spr_dmmucfgr(regs[3]), .spr_immucfgr(regs[4]), .spr_dccfgr(regs[5]),
    .spr_iccfgr(regs[6]), .spr_dcfgr(regs[7]), .spr_pccfgr(regs[8]), .spr_avr(regs[10]),
    .err_clear_i(clr), .spr_bus_dat_o(dat[1]), .spr_bus_ack_o(ack[1]),
    .spr_access_err_o(err[1]), .spr_err_count_o(cnt[1]));

  mor1kx_cfgrs_spr_slave #(.OPTION_READ_LATENCY(4), .FEATURE_WRITE_ERROR("ENABLED")) u_l4 (
    .clk(clk), .rst(rst), .spr_bus_addr_i(addr), .spr_bus_we_i(we), .spr_bus_stb_i(stb),
    .spr_bus_dat_i(dat_i), .spr_vr(regs[0]), .spr_vr2(regs[9]), .spr_upr(regs[1]),
    .spr_cpucfgr(regs[2]), .spr_dmmucfgr(regs[3]), .spr_immucfgr(regs[4]), .spr_dccfgr(regs[5]),
    .spr_iccfgr(regs[6]), .spr_dcfgr(regs[7]), .spr_pccfgr(regs[8]), .spr_avr(regs[10]),
    .err_clear_i(clr), .spr_bus_dat_o(dat[2]), .spr_bus_ack_o(ack[2]),
    .spr_access_err_o(err[2]), .spr_err_count_o(cnt[2]));

  mor1kx_cfgrs_spr_slave #(.OPTION_READ_LATENCY(2), .FEATURE_WRITE_ERROR("NONE")) u_nw (
    .clk(clk), .rst(rst), .spr_bus_addr_i(addr), .spr_bus_we_i(we), .spr_bus_stb_i(stb),
    .spr_bus_dat_i(dat_i), .spr_vr(regs[0]), .spr_vr2(regs[9]), .spr_upr(regs[1]),
    .spr_cpucfgr(regs[2]), .spr_dmmucfgr(regs[3]), .spr_immucfgr(regs[4]), .spr_dccfgr(regs[5]),
    .spr_iccfgr(regs[6]), .spr_dcfgr(regs[7]), .spr_pccfgr(regs[8]), .spr_avr(regs[10]),
    .err_clear_i(clr), .spr_bus_dat_o(dat[3]), .spr_bus_ack_o(ack[3]),
    .spr_access_err_o(err[3]), .spr_err_count_o(cnt[3]));

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  function automatic void chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s inst%0d: got %h, required %h (t=%0t)", name, inst, act, exp, $time);
  endfunction

  // Transaction model: a captured access ages by one per cycle the strobe stays up and
  // acks once its age reaches latency-1; after an ack the slave is busy until stb is low.
  bit          m_pend [0:3];
  int unsigned m_age  [0:3];
  logic [31:0] m_snap [0:3];
  bit          m_we   [0:3];
  bit          m_hold [0:3];
  bit          m_ack  [0:3];
  logic [31:0] m_dat  [0:3];
  bit          m_err  [0:3];
  int unsigned m_cnt  [0:3];
  bit          na;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      na = 1'b0;
      if (rst) begin
        m_pend[i] = 0; m_hold[i] = 0; m_ack[i] = 0; m_dat[i] = '0; m_err[i] = 0; m_cnt[i] = 0;
      end else begin
        if (m_ack[i] && m_we[i] && feat[i]) begin
          m_err[i] = 1;
          m_cnt[i] = clr ? 1 : ((m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1);
        end else if (clr) begin
          m_err[i] = 0; m_cnt[i] = 0;
        end
        if (m_ack[i]) m_hold[i] = 1;
        else if (m_hold[i]) m_hold[i] = stb;
        else if (m_pend[i]) begin
          if (!stb) m_pend[i] = 0;
          else begin
            m_age[i]++;
            if (m_age[i] == lat[i] - 1) begin na = 1'b1; m_pend[i] = 0; end
          end
        end else if (stb && addr[15:11] == 5'd0 && addr[10:0] <= 11'd10) begin
          m_snap[i] = regs[addr[3:0]];
          m_we[i]   = we;
          if (lat[i] == 1) na = 1'b1;
          else begin m_pend[i] = 1; m_age[i] = 0; end
        end
        m_ack[i] = na;
        m_dat[i] = (na && !m_we[i]) ? m_snap[i] : '0;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        chk("ack", i, 32'(ack[i]), 32'(m_ack[i]));
        chk("dat", i, dat[i], m_dat[i]);
        chk("err", i, 32'(err[i]), 32'(m_err[i]));
        chk("cnt", i, 32'(cnt[i]), m_cnt[i]);
      end
    end
  end

  int unsigned tcount;
  int unsigned nack     [0:3];
  int unsigned first_ack[0:3];
  logic [31:0] ackdat   [0:3];

  task automatic tick();
    @(posedge clk); #2;
    tcount++;
    for (int i = 0; i < 4; i++)
      if (ack[i]) begin
        nack[i]++;
        if (nack[i] == 1) begin first_ack[i] = tcount; ackdat[i] = dat[i]; end
      end
  endtask

  task automatic start(input logic [15:0] a, input logic w);
    addr = a; we = w; dat_i = (w ? 32'hDEADBEEF : $urandom); stb = 1'b1;
    tcount = 0;
    for (int i = 0; i < 4; i++) begin nack[i] = 0; first_ack[i] = 0; ackdat[i] = 'x; end
  endtask

  task automatic xfer(input logic [15:0] a, input logic w, input int unsigned n);
    start(a, w);
    repeat (n) tick();
    stb = 1'b0;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i <= 10; i++) regs[i] = $urandom;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_ack", i, 32'(ack[i]), 32'd0);
      chk("rst_cnt", i, 32'(cnt[i]), 32'd0);
    end

    // Latency-1 read of VR2: ack one cycle after strobe, data for that cycle only.
    regs[9] = 32'h12345600;
    start(16'h0009, 1'b0);
    tick();
    chk("t1_ack", 0, 32'(ack[0]), 32'd1);
    chk("t1_dat", 0, dat[0], 32'h12345600);
    tick();
    chk("t1_ack_off", 0, 32'(ack[0]), 32'd0);
    chk("t1_dat_off", 0, dat[0], 32'd0);
    repeat (4) tick();
    stb = 1'b0; tick(); tick();
    for (int i = 0; i < 4; i++) chk("t1_lat", i, first_ack[i], lat[i]);

    // Latency-3 read with the register changing after capture.
    regs[2] = 32'h00000220;
    start(16'h0002, 1'b0);
    tick();
    regs[2] = 32'hFFFFFFFF;
    repeat (6) tick();
    stb = 1'b0; tick(); tick();
    chk("t2_lat", 1, first_ack[1], 32'd3);
    chk("t2_dat", 1, ackdat[1], 32'h00000220);
    chk("t2_dat_l4", 2, ackdat[2], 32'h00000220);
    chk("t2_one_ack", 1, nack[1], 32'd1);

    // Writes are acked with zero data and logged (except where logging is disabled).
    xfer(16'h0001, 1'b1, 6);
    chk("t3_dat", 0, ackdat[0], 32'd0);
    chk("t3_err", 0, 32'(err[0]), 32'd1);
    chk("t3_cnt", 0, 32'(cnt[0]), 32'd1);
    repeat (300) xfer(16'h0001, 1'b1, 5);
    chk("t3_sat", 0, 32'(cnt[0]), 32'hFF);
    chk("t3_sat_l4", 2, 32'(cnt[2]), 32'hFF);
    chk("t3_none_cnt", 3, 32'(cnt[3]), 32'd0);

    // Clear landing on the ACK cycle of an erroring write: flag stays, count is 1.
    start(16'h0001, 1'b1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr_err", 0, 32'(err[0]), 32'd1);
    chk("t4_clr_cnt", 0, 32'(cnt[0]), 32'd1);
    repeat (4) tick();
    stb = 1'b0; tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clear_err", 0, 32'(err[0]), 32'd0);
    chk("t3_clear_cnt", 0, 32'(cnt[0]), 32'd0);

    // Strobes outside the decoded range are ignored.
    foreach (lat[k]) begin
      logic [15:0] miss [0:2];
      miss = '{16'h000B, 16'h0011, 16'h0800};
      if (k < 3) begin
        start(miss[k], k[0]);
        repeat (4) tick();
        stb = 1'b0; tick();
        for (int i = 0; i < 4; i++) chk("t4_nohit", i, nack[i], 32'd0);
      end
    end

    // Strobe withdrawn during WAIT, then reset during WAIT.
    start(16'h0003, 1'b0);
    tick(); tick();
    stb = 1'b0;
    repeat (4) tick();
    chk("t5_abort", 2, nack[2], 32'd0);
    start(16'h0001, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_ack", 2, 32'(ack[2]), 32'd0);
    chk("t5_rst_dat", 2, dat[2], 32'd0);
    chk("t5_rst_cnt", 0, 32'(cnt[0]), 32'd0);
    rst = 1'b0; stb = 1'b0;
    repeat (3) tick();
    chk("t5_rst_nocount", 2, 32'(cnt[2]), 32'd0);
    regs[10] = 32'h01010000;
    xfer(16'h000A, 1'b0, 6);
    chk("t5_lat", 2, first_ack[2], 32'd4);
    chk("t5_dat", 2, ackdat[2], 32'h01010000);

    // Write with logging disabled.
    xfer(16'h0005, 1'b1, 6);
    chk("t6_ack", 3, nack[3], 32'd1);
    chk("t6_dat", 3, ackdat[3], 32'd0);
    chk("t6_err", 3, 32'(err[3]), 32'd0);
    chk("t6_cnt", 3, 32'(cnt[3]), 32'd0);

    // Randomised traffic, including glitchy strobes, clears and resets.
    repeat (3000) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) != 0) stb = ~stb | ($urandom_range(0, 3) != 0);
      else stb = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        addr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
        we   = $urandom_range(0, 1) == 1;
      end
      dat_i = $urandom;
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 10)] = $urandom;
      tick();
    end
    rst = 1'b0; clr = 1'b0; stb = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/mor1kx_cfgrs_spr_slave.md
Name: mor1kx_cfgrs_spr_slave

Overview:
SPR-bus responder for the read-only configuration/version registers of SPR group 0 (VR, UPR, CPUCFGR, DMMUCFGR, IMMUCFGR, DCCFGR, ICCFGR, DCFGR, PCCFGR, VR2, AVR).
- Takes the static register words from the configuration-register block.
- Answers SPR bus read strobes with a configurable, fixed-latency, single-pulse ack.
- Acks writes to these registers without effect and records them as access errors.
- Sits on the SPR bus beside the other group-0 responders in the CPU control stage.

Parameters:
OPTION_READ_LATENCY, 1, cycles from accepted strobe to ack; legal range 1..4.
FEATURE_WRITE_ERROR, "ENABLED", when "NONE" writes are acked silently: no flag, no count.

Ports:
clk  input  1  core clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
spr_bus_addr_i  input  16  SPR address; [15:11] group, [10:0] index
spr_bus_we_i  input  1  1 = write, 0 = read
spr_bus_stb_i  input  1  access strobe; held by initiator until ack seen
spr_bus_dat_i  input  32  write data (ignored)
spr_vr, spr_vr2, spr_upr, spr_cpucfgr, spr_dmmucfgr, spr_immucfgr, spr_dccfgr, spr_iccfgr, spr_dcfgr, spr_pccfgr, spr_avr  input  32 each  register values
err_clear_i  input  1  clears error flag and count
spr_bus_dat_o  output  32  read data; valid only while ack=1, else 0
spr_bus_ack_o  output  1  one-cycle ack pulse
spr_access_err_o  output  1  sticky: a write hit a read-only register
spr_err_count_o  output  8  saturating count of such writes

Behaviour:
- Reset (sync, active high): FSM=IDLE; spr_bus_ack_o=0; spr_bus_dat_o=0; spr_access_err_o=0; spr_err_count_o=0.
- Hit decode: addr[15:11]==0 and addr[10:0] in 0x000..0x00A.
  - Index map: 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 0xA AVR.
  - Non-hit strobes are ignored entirely: no ack, no state change.
- FSM states:
  - IDLE: on stb && hit, capture index, we, and a snapshot of the selected register.
    - OPTION_READ_LATENCY==1: go to ACK.
    - Otherwise: go to WAIT with counter = OPTION_READ_LATENCY-1.
  - WAIT: decrement counter each cycle; when it reaches 1, go to ACK.
    - If stb drops while in WAIT: abort to IDLE; no ack, no error recorded.
  - ACK: ack_o=1 for exactly this cycle.
    - dat_o = snapshot for a read, 0 for a write.
    - Next state is always HOLD.
  - HOLD: ack_o=0, dat_o=0; stay while stb=1; go to IDLE when stb=0.
    - Guarantees one ack per strobe and at least one idle cycle between accesses.
- Latency: ack is asserted exactly OPTION_READ_LATENCY cycles after the first cycle stb&&hit is sampled in IDLE.
- Snapshot: data is taken at capture; register input changes during WAIT do not affect dat_o.
- Address/we changes after capture are ignored until the next IDLE.
- Write to a hit, FEATURE_WRITE_ERROR enabled, in the ACK cycle:
  - err flag <= 1.
  - count <= count+1, saturating at 0xFF.
- err_clear_i: flag<=0 and count<=0, except when it coincides with an ACK-cycle write error; then flag=1 and count=1 (clear applied first, then increment).
- Reset mid-operation (WAIT/ACK/HOLD): returns to IDLE next cycle; no ack; the pending write is not counted.
- Parameter check: OPTION_READ_LATENCY outside 1..4 is a synthesis-time error.

Test Plan:
1. Latency 1, read addr 0x0009 with spr_vr2=0x12345600 held -> ack=1 exactly 1 cycle after strobe, dat_o=0x12345600 for that cycle only.
2. Latency 3, read 0x0002 and change spr_cpucfgr from 0x00000220 to 0xFFFFFFFF one cycle after strobe -> ack at cycle +3, dat_o=0x00000220; stb held 2 extra cycles -> no second ack.
3. Write 0x0001 with dat_i=0xDEADBEEF -> ack with dat_o=0, err flag=1, count=1; 300 such writes -> count saturates at 0xFF; err_clear_i -> 0/0.
4. Strobes to 0x000B, 0x0011 and 0x0800 -> ack stays 0 and FSM stays IDLE; simultaneous err_clear_i with an erroring write ack -> flag=1, count=1.
5. Latency 4: drop stb during WAIT -> no ack; assert rst during WAIT -> no ack and outputs at reset values; next read of 0x000A returns spr_avr (e.g. 0x01010000) with full latency.
6. FEATURE_WRITE_ERROR="NONE": write 0x0005 -> acked with dat_o=0, flag stays 0, count stays 0.
